// File: rtl/riscv_mem_arbiter.sv
// riscv_mem_arbiter: shares one memory port between instruction fetch and data access.
// Ports:
//   clk_i, reset_i (async, active-low)
//   iaddr_i/ird_i            -> irdata_o/ivalid_o   instruction requester
//   daddr_i/dwdata_i/dsize_i/drd_i/dwr_i -> drdata_o/dvalid_o   data requester
//   maddr_o/mwdata_o/msize_o/mrd_o/mwr_o <- mrdata_i/mready_i   shared memory
//   busy_o (transaction in flight), err_o (sticky timeout flag)
module riscv_mem_arbiter #(
  parameter int unsigned TIMEOUT  = 16,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [31:0] iaddr_i,
  input  logic        ird_i,
  output logic [31:0] irdata_o,
  output logic        ivalid_o,
  input  logic [31:0] daddr_i,
  input  logic [31:0] dwdata_i,
  input  logic [1:0]  dsize_i,
  input  logic        drd_i,
  input  logic        dwr_i,
  output logic [31:0] drdata_o,
  output logic        dvalid_o,
  output logic [31:0] maddr_o,
  output logic [31:0] mwdata_o,
  output logic [1:0]  msize_o,
  output logic        mrd_o,
  output logic        mwr_o,
  input  logic [31:0] mrdata_i,
  input  logic        mready_i,
  output logic        busy_o,
  output logic        err_o
);

  localparam int unsigned DW    = 32;
  localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [1:0]  SIZE_WORD = 2'b10;
  // RESET_PC is reserved for future fetch-address checks; it contributes only a constant zero.
  localparam logic [DW-1:0] IDLE_ADDR = RESET_PC & 32'h0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IFETCH = 2'd1,
    DACC   = 2'd2
  } state_e;

  state_e state_q, state_d;

  // Pending request slots
  logic            i_pend_q, d_pend_q;
  logic [DW-1:0]   i_addr_q, d_addr_q, d_wdata_q;
  logic [1:0]      d_size_q;
  logic            d_wr_q;

  // Granted transaction, frozen so later overwrites of a slot cannot disturb the bus
  logic [DW-1:0]   t_addr_q, t_wdata_q;
  logic [1:0]      t_size_q;
  logic            t_wr_q;

  logic            last_d_q;
  logic [CNT_W-1:0] cnt_q;
  logic            err_q;
  logic [DW-1:0]   irdata_q, drdata_q;

  logic            d_pulse, i_req, d_req;
  logic            grant_i, grant_d;
  logic            busy, timeout_c, done_c;
  logic [DW-1:0]   cmpl_data;

  // Request eligibility: pending slot or same-cycle pulse
  assign d_pulse   = drd_i | dwr_i;
  assign i_req     = i_pend_q | ird_i;
  assign d_req     = d_pend_q | d_pulse;
  assign busy      = (state_q != IDLE);
  assign timeout_c = busy && !mready_i && (cnt_q == CNT_W'(TIMEOUT - 1));
  assign done_c    = busy && (mready_i || timeout_c);
  assign cmpl_data = mready_i ? mrdata_i : '0;

  // Next-state and grant decision
  always_comb begin
    state_d = state_q;
    grant_i = 1'b0;
    grant_d = 1'b0;
    case (state_q)
      IDLE: begin
        // Data wins unless it also won last time and a fetch is waiting
        if (i_req && (!d_req || last_d_q)) begin
          grant_i = 1'b1;
          state_d = IFETCH;
        end else if (d_req) begin
          grant_d = 1'b1;
          state_d = DACC;
        end
      end
      IFETCH, DACC: begin
        if (done_c) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Slots, transaction capture, wait counter, sticky error and read-data hold
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      i_pend_q  <= 1'b0;
      i_addr_q  <= '0;
      d_pend_q  <= 1'b0;
      d_addr_q  <= '0;
      d_wdata_q <= '0;
      d_size_q  <= SIZE_WORD;
      d_wr_q    <= 1'b0;
      t_addr_q  <= '0;
      t_wdata_q <= '0;
      t_size_q  <= SIZE_WORD;
      t_wr_q    <= 1'b0;
      last_d_q  <= 1'b0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      irdata_q  <= '0;
      drdata_q  <= '0;
    end else begin
      // A granted slot moves into the transaction registers; later pulses refill it
      if (grant_i) begin
        i_pend_q <= 1'b0;
      end else if (ird_i) begin
        i_pend_q <= 1'b1;
        i_addr_q <= iaddr_i;
      end
      if (grant_d) begin
        d_pend_q <= 1'b0;
      end else if (d_pulse) begin
        d_pend_q  <= 1'b1;
        d_addr_q  <= daddr_i;
        d_wdata_q <= dwdata_i;
        d_size_q  <= dsize_i;
        d_wr_q    <= dwr_i;
      end

      if (grant_i) begin
        t_addr_q  <= ird_i ? iaddr_i : i_addr_q;
        t_wdata_q <= '0;
        t_size_q  <= SIZE_WORD;
        t_wr_q    <= 1'b0;
        last_d_q  <= 1'b0;
      end else if (grant_d) begin
        t_addr_q  <= d_pulse ? daddr_i  : d_addr_q;
        t_wdata_q <= d_pulse ? dwdata_i : d_wdata_q;
        t_size_q  <= d_pulse ? dsize_i  : d_size_q;
        t_wr_q    <= d_pulse ? dwr_i    : d_wr_q;
        last_d_q  <= 1'b1;
      end

      if (!busy || done_c) cnt_q <= '0;
      else                 cnt_q <= cnt_q + CNT_W'(1);

      if (timeout_c) err_q <= 1'b1;
      if (ivalid_o)  irdata_q <= cmpl_data;
      if (dvalid_o)  drdata_q <= cmpl_data;
    end
  end

  // Bus and completion outputs (completion is same-cycle with mready_i)
  assign busy_o   = busy;
  assign err_o    = err_q;
  assign mrd_o    = (state_q == IFETCH) || ((state_q == DACC) && !t_wr_q);
  assign mwr_o    = (state_q == DACC) && t_wr_q;
  assign maddr_o  = busy ? t_addr_q  : IDLE_ADDR;
  assign mwdata_o = busy ? t_wdata_q : '0;
  assign msize_o  = busy ? t_size_q  : SIZE_WORD;
  assign ivalid_o = (state_q == IFETCH) && done_c;
  assign dvalid_o = (state_q == DACC) && done_c;
  assign irdata_o = ivalid_o ? cmpl_data : irdata_q;
  assign drdata_o = dvalid_o ? cmpl_data : drdata_q;

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// tb_riscv_mem_arbiter: directed table vectors plus hand-written multi-cycle sequences.
module tb_riscv_mem_arbiter;

  localparam logic [1:0] W = 2'b10;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [31:0] iaddr_i, daddr_i, dwdata_i, mrdata_i;
  logic        ird_i, drd_i, dwr_i, mready_i;
  logic [1:0]  dsize_i;
  logic [31:0] irdata_o, drdata_o, maddr_o, mwdata_o;
  logic        ivalid_o, dvalid_o, mrd_o, mwr_o, busy_o, err_o;
  logic [1:0]  msize_o;

  riscv_mem_arbiter #(.TIMEOUT(16), .RESET_PC(32'h0)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .iaddr_i(iaddr_i), .ird_i(ird_i), .irdata_o(irdata_o), .ivalid_o(ivalid_o),
    .daddr_i(daddr_i), .dwdata_i(dwdata_i), .dsize_i(dsize_i),
    .drd_i(drd_i), .dwr_i(dwr_i), .drdata_o(drdata_o), .dvalid_o(dvalid_o),
    .maddr_o(maddr_o), .mwdata_o(mwdata_o), .msize_o(msize_o),
    .mrd_o(mrd_o), .mwr_o(mwr_o), .mrdata_i(mrdata_i), .mready_i(mready_i),
    .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic ird; logic [31:0] iaddr; logic drd; logic dwr;
    logic [31:0] daddr; logic [31:0] dwdata; logic [1:0] dsize;
    logic mready; logic [31:0] mrdata;
  } in_t;

  typedef struct packed {
    logic mrd; logic mwr; logic [31:0] maddr; logic [31:0] mwdata; logic [1:0] msize;
    logic ivalid; logic [31:0] irdata; logic dvalid; logic [31:0] drdata;
    logic busy; logic err;
  } obs_t;

  typedef struct { in_t stim; obs_t want; } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic in_t mk_in(logic ird, logic [31:0] iaddr, logic drd, logic dwr,
                                logic [31:0] daddr, logic [31:0] dwdata, logic [1:0] dsize,
                                logic mready, logic [31:0] mrdata);
    return '{ird, iaddr, drd, dwr, daddr, dwdata, dsize, mready, mrdata};
  endfunction

  function automatic obs_t idle_obs(logic [31:0] ird, logic [31:0] drd);
    return '{1'b0, 1'b0, 32'h0, 32'h0, W, 1'b0, ird, 1'b0, drd, 1'b0, 1'b0};
  endfunction

  function automatic obs_t act_obs(logic mrd, logic mwr, logic [31:0] maddr, logic [31:0] mwdata,
                                   logic [1:0] msize, logic iv, logic [31:0] ird, logic dv,
                                   logic [31:0] drd);
    return '{mrd, mwr, maddr, mwdata, msize, iv, ird, dv, drd, 1'b1, 1'b0};
  endfunction

  function automatic obs_t sample();
    return '{mrd_o, mwr_o, maddr_o, mwdata_o, msize_o, ivalid_o, irdata_o, dvalid_o, drdata_o,
             busy_o, err_o};
  endfunction

  task automatic drive(input in_t s);
    ird_i = s.ird; iaddr_i = s.iaddr; drd_i = s.drd; dwr_i = s.dwr;
    daddr_i = s.daddr; dwdata_i = s.dwdata; dsize_i = s.dsize;
    mready_i = s.mready; mrdata_i = s.mrdata;
  endtask

  task automatic quiet();
    drive(mk_in(0, 0, 0, 0, 0, 0, 2'b00, 0, 0));
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  task automatic chk_obs(input string name, input obs_t got, input obs_t want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got mrd=%b mwr=%b maddr=%h mwdata=%h msize=%b iv=%b ird=%h dv=%b drd=%h busy=%b err=%b, expected mrd=%b mwr=%b maddr=%h mwdata=%h msize=%b iv=%b ird=%h dv=%b drd=%h busy=%b err=%b",
               name, got.mrd, got.mwr, got.maddr, got.mwdata, got.msize, got.ivalid, got.irdata,
               got.dvalid, got.drdata, got.busy, got.err, want.mrd, want.mwr, want.maddr,
               want.mwdata, want.msize, want.ivalid, want.irdata, want.dvalid, want.drdata,
               want.busy, want.err);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0]  order[$];
    logic [7:0]  exp_order [6];
    int          nbusy, nfetch;
    logic        seen;
    logic [31:0] got_d, fetch_addr;

    exp_order = '{8'h44, 8'h49, 8'h44, 8'h49, 8'h44, 8'h49};

    // Single-cycle directed vectors
    tbl.push_back('{mk_in(0, 0, 0, 0, 0, 0, 2'b00, 0, 0), idle_obs(0, 0)});
    tbl.push_back('{mk_in(1, 32'h100, 0, 0, 0, 0, 2'b00, 0, 0), idle_obs(0, 0)});
    tbl.push_back('{mk_in(0, 0, 0, 0, 0, 0, 2'b00, 1, 32'h13), act_obs(1, 0, 32'h100, 0, W, 1, 32'h13, 0, 0)});
    tbl.push_back('{mk_in(0, 0, 0, 0, 0, 0, 2'b00, 0, 0), idle_obs(32'h13, 0)});
    tbl.push_back('{mk_in(1, 32'h200, 0, 1, 32'h2000, 32'hDEADBEEF, W, 0, 0), idle_obs(32'h13, 0)});
    tbl.push_back('{mk_in(0, 0, 0, 0, 0, 0, 2'b00, 1, 0), act_obs(0, 1, 32'h2000, 32'hDEADBEEF, W, 0, 32'h13, 1, 0)});
    tbl.push_back('{mk_in(0, 0, 0, 0, 0, 0, 2'b00, 0, 0), idle_obs(32'h13, 0)});
    tbl.push_back('{mk_in(0, 0, 0, 0, 0, 0, 2'b00, 1, 32'h93), act_obs(1, 0, 32'h200, 0, W, 1, 32'h93, 0, 0)});
    tbl.push_back('{mk_in(0, 0, 0, 0, 0, 0, 2'b00, 0, 0), idle_obs(32'h93, 0)});
    tbl.push_back('{mk_in(0, 0, 1, 0, 32'h3001, 0, 2'b00, 0, 0), idle_obs(32'h93, 0)});
    tbl.push_back('{mk_in(0, 0, 0, 0, 0, 0, 2'b00, 0, 0), act_obs(1, 0, 32'h3001, 0, 2'b00, 0, 32'h93, 0, 0)});
    tbl.push_back('{mk_in(0, 0, 0, 0, 0, 0, 2'b00, 1, 32'hCAFEF00D), act_obs(1, 0, 32'h3001, 0, 2'b00, 0, 32'h93, 1, 32'hCAFEF00D)});
    tbl.push_back('{mk_in(0, 0, 0, 0, 0, 0, 2'b00, 0, 0), idle_obs(32'h93, 32'hCAFEF00D)});
    tbl.push_back('{mk_in(1, 32'h300, 0, 0, 0, 0, 2'b00, 0, 0), idle_obs(32'h93, 32'hCAFEF00D)});
    tbl.push_back('{mk_in(1, 32'h304, 0, 0, 0, 0, 2'b00, 1, 32'h11), act_obs(1, 0, 32'h300, 0, W, 1, 32'h11, 0, 32'hCAFEF00D)});
    tbl.push_back('{mk_in(0, 0, 0, 0, 0, 0, 2'b00, 0, 0), idle_obs(32'h11, 32'hCAFEF00D)});
    tbl.push_back('{mk_in(0, 0, 0, 0, 0, 0, 2'b00, 1, 32'h22), act_obs(1, 0, 32'h304, 0, W, 1, 32'h22, 0, 32'hCAFEF00D)});
    tbl.push_back('{mk_in(0, 0, 0, 0, 0, 0, 2'b00, 1, 32'hFFFF), idle_obs(32'h22, 32'hCAFEF00D)});

    // Reset state
    reset_i = 1'b0;
    quiet();
    @(negedge clk_i);
    @(negedge clk_i);
    chk_obs("reset_state", sample(), idle_obs(0, 0));
    reset_i = 1'b1;
    tick();

    // Table
    foreach (tbl[i]) begin
      drive(tbl[i].stim);
      @(negedge clk_i);
      chk_obs($sformatf("vec%0d", i), sample(), tbl[i].want);
      tick();
    end

    // Alternation under continuous contention
    drive(mk_in(1, 32'h400, 1, 0, 32'h800, 0, W, 1, 32'h5));
    for (int c = 0; c < 12; c++) begin
      @(negedge clk_i);
      if (dvalid_o) order.push_back(8'h44);
      if (ivalid_o) order.push_back(8'h49);
      tick();
    end
    chk("alt_count", 32'(order.size()), 32'd6);
    for (int k = 0; k < 6; k++) begin
      if (k < order.size()) chk($sformatf("alt_grant%0d", k), 32'(order[k]), 32'(exp_order[k]));
      else                  chk($sformatf("alt_grant%0d", k), 32'h0, 32'(exp_order[k]));
    end
    drive(mk_in(0, 0, 0, 0, 0, 0, 2'b00, 1, 0));
    for (int c = 0; c < 8; c++) tick();
    mready_i = 1'b0;
    @(negedge clk_i);
    chk("alt_drained_busy", 32'(busy_o), 32'd0);
    chk("err_before_timeout", 32'(err_o), 32'd0);
    tick();

    // Timeout on a stalled data read
    drive(mk_in(0, 0, 1, 0, 32'h4000, 0, W, 0, 32'h12345678));
    tick();
    drd_i = 1'b0;
    nbusy = 0;
    seen  = 1'b0;
    got_d = 32'hFFFFFFFF;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk_i);
      if (busy_o) nbusy++;
      if (dvalid_o) begin
        seen  = 1'b1;
        got_d = drdata_o;
      end
      tick();
    end
    chk("timeout_seen", 32'(seen), 32'd1);
    chk("timeout_cycles", 32'(nbusy), 32'd16);
    chk("timeout_drdata", got_d, 32'h0);
    @(negedge clk_i);
    chk("timeout_err", 32'(err_o), 32'd1);
    chk("timeout_idle", 32'(busy_o), 32'd0);
    tick();
    drive(mk_in(1, 32'h500, 0, 0, 0, 0, 2'b00, 0, 0));
    tick();
    drive(mk_in(0, 0, 0, 0, 0, 0, 2'b00, 1, 32'h73));
    @(negedge clk_i);
    chk_obs("post_timeout_fetch", sample(),
            '{1'b1, 1'b0, 32'h500, 32'h0, W, 1'b1, 32'h73, 1'b0, 32'h0, 1'b1, 1'b1});
    tick();
    quiet();
    for (int c = 0; c < 3; c++) tick();
    @(negedge clk_i);
    chk("err_sticky", 32'(err_o), 32'd1);
    tick();

    // Asynchronous reset during a stalled fetch
    drive(mk_in(1, 32'h600, 0, 0, 0, 0, 2'b00, 0, 32'hAA));
    tick();
    ird_i = 1'b0;
    tick();
    tick();
    @(negedge clk_i);
    chk("pre_reset_busy", 32'({busy_o, mrd_o}), 32'd3);
    #2 reset_i = 1'b0;
    #1;
    chk_obs("async_reset", sample(), idle_obs(0, 0));
    tick();
    reset_i = 1'b1;
    mready_i = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_i);
      chk($sformatf("post_reset%0d", c), 32'({ivalid_o, busy_o}), 32'd0);
      tick();
    end

    // Overwrite of the fetch slot while a data access is stalled
    drive(mk_in(0, 0, 1, 0, 32'h7000, 0, W, 0, 0));
    tick();
    drive(mk_in(1, 32'h10, 0, 0, 0, 0, 2'b00, 0, 0));
    tick();
    ird_i = 1'b0;
    tick();
    drive(mk_in(1, 32'h14, 0, 0, 0, 0, 2'b00, 0, 0));
    tick();
    drive(mk_in(0, 0, 0, 0, 0, 0, 2'b00, 1, 32'h33));
    nfetch     = 0;
    fetch_addr = 32'hFFFFFFFF;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_i);
      if (ivalid_o) begin
        nfetch++;
        fetch_addr = maddr_o;
      end
      tick();
    end
    chk("overwrite_fetch_count", 32'(nfetch), 32'd1);
    chk("overwrite_fetch_addr", fetch_addr, 32'h14);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
